// File: rtl/pvs_pkg.sv
// pvs_pkg: shared state encoding and timing constants for pin_vector_sequencer
package pvs_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_PLOAD, S_PXFER, S_RUN, S_DONE} state_t;
  localparam logic [7:0] MIN_CYCLE_LENGTH = 8'd4;
  localparam logic [7:0] LOAD_GUARD = 8'd3;
endpackage

// File: rtl/pvs_cycle_timer.sv
// pvs_cycle_timer: tester-cycle wrap counter with load-window and cycle-end flags
module pvs_cycle_timer
  import pvs_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] len,
  input  logic [6:0] load_off,
  output logic       at_off,
  output logic       win_end,
  output logic       at_last
);
  logic [7:0] cnt;
  logic [7:0] win_last;
  logic [7:0] off;
  assign win_last = len - LOAD_GUARD;
  // an offset past the window end is pulled back so a vector can still load before the cycle ends
  assign off = ({1'b0, load_off} < win_last) ? {1'b0, load_off} : win_last;
  assign at_off = cnt == off;
  assign win_end = cnt == win_last;
  assign at_last = cnt == len - 8'd1;
  always_ff @(posedge CLK)
    if (!RST_N || clr) cnt <= '0;
    else if (en) cnt <= at_last ? '0 : cnt + 8'd1;
endmodule

// File: rtl/pin_vector_sequencer.sv
// pin_vector_sequencer: streams test vectors into the per-pin double-buffered register stage
module pin_vector_sequencer
  import pvs_pkg::*;
#(
  parameter int VEC_COUNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   STOP,
  input  logic [VEC_COUNT_W-1:0] NUM_VECTORS,
  input  logic [7:0]             CYCLE_LENGTH,
  input  logic [6:0]             LOAD_OFFSET,
  input  logic                   VEC_VALID,
  input  logic                   VEC_D,
  input  logic                   VEC_FF,
  input  logic                   VEC_TEST,
  output logic                   VEC_READY,
  output logic                   D,
  output logic                   FF,
  output logic                   LOAD_SIG,
  output logic                   LOAD_FF,
  output logic                   TRANSFER_SIG,
  output logic                   TRANSFER_FF,
  output logic                   TEST_CYCLE,
  output logic                   EN_FF_LOGIC,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   UNDERRUN,
  output logic                   CFG_ERR,
  output logic [VEC_COUNT_W-1:0] VEC_INDEX
);
  state_t state, nxt;
  logic [VEC_COUNT_W-1:0] num;
  logic [7:0] cyc_len;
  logic [6:0] load_off;
  logic pend_test, load_p, loaded, win_open;
  logic at_off, win_end, at_last;
  logic idle, run, start_ok, more, in_win, acc, xfer, xfer_e, ur_set;

  pvs_cycle_timer u_timer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (!run),
    .en      (run),
    .len     (cyc_len),
    .load_off(load_off),
    .at_off  (at_off),
    .win_end (win_end),
    .at_last (at_last)
  );

  assign idle = state == S_IDLE;
  assign run = state == S_RUN;
  assign start_ok = idle & START & !STOP & (CYCLE_LENGTH >= MIN_CYCLE_LENGTH);
  assign more = VEC_INDEX < num;
  assign in_win = at_off | win_open;
  // loaded doubles as "already accepted this tester cycle" since it clears only on TRANSFER
  assign VEC_READY = !STOP & (state == S_PRIME | run & in_win & !loaded & more);
  assign acc = VEC_VALID & VEC_READY;
  assign xfer = state == S_PXFER | run & at_last & loaded;
  assign xfer_e = xfer & !STOP;
  assign ur_set = run & win_end & !loaded & !acc & more & !STOP;
  assign {LOAD_SIG, LOAD_FF} = {2{load_p}};
  assign {TRANSFER_SIG, TRANSFER_FF} = {2{xfer}};
  assign BUSY = !idle & state != S_DONE;
  assign DONE = state == S_DONE;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start_ok ? (NUM_VECTORS == '0 ? S_DONE : S_PRIME) : S_IDLE;
      S_PRIME: nxt = acc ? S_PLOAD : S_PRIME;
      S_PLOAD: nxt = S_PXFER;
      S_PXFER: nxt = S_RUN;
      S_RUN:   nxt = (!at_last || loaded) ? S_RUN : UNDERRUN ? S_IDLE : S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (STOP) nxt = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
      num <= '0;
      cyc_len <= '0;
      load_off <= '0;
      D <= 1'b0;
      FF <= 1'b0;
      pend_test <= 1'b0;
      load_p <= 1'b0;
      loaded <= 1'b0;
      win_open <= 1'b0;
      TEST_CYCLE <= 1'b0;
      EN_FF_LOGIC <= 1'b0;
      UNDERRUN <= 1'b0;
      CFG_ERR <= 1'b0;
      VEC_INDEX <= '0;
    end else begin
      state <= nxt;
      load_p <= acc;
      loaded <= (acc | loaded & !xfer) & (nxt != S_IDLE);
      win_open <= run & in_win & !win_end;
      TEST_CYCLE <= (nxt == S_IDLE) ? 1'b0 : xfer_e ? pend_test : TEST_CYCLE;
      EN_FF_LOGIC <= (state == S_PXFER | EN_FF_LOGIC) & (nxt == S_RUN) & !ur_set;
      CFG_ERR <= idle & START & !STOP & (CYCLE_LENGTH < MIN_CYCLE_LENGTH);
      if (acc) begin
        D <= VEC_D;
        FF <= VEC_FF;
        pend_test <= VEC_TEST;
      end
      if (ur_set) UNDERRUN <= 1'b1;
      if (start_ok) begin
        num <= NUM_VECTORS;
        cyc_len <= CYCLE_LENGTH;
        load_off <= LOAD_OFFSET;
        UNDERRUN <= 1'b0;
        VEC_INDEX <= '0;
      end else if (xfer_e) VEC_INDEX <= VEC_INDEX + 1'b1;
    end
  end
endmodule
